// File: rtl/ahbl_pkg.sv
// ============================================================================
// Module      : ahbl_pkg
// Description : Shared AHB-Lite protocol codes and stream-writer FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahbl_pkg;

    // HTRANS transfer types
    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;

    // Burst type and transfer size used by this master
    localparam logic [2:0] c_HBURST_INCR   = 3'b001;
    localparam logic [2:0] c_HSIZE_WORD    = 3'b010;

    // HRESP response codes
    localparam logic [1:0] c_HRESP_OKAY    = 2'b00;
    localparam logic [1:0] c_HRESP_ERROR   = 2'b01;
    localparam logic [1:0] c_HRESP_RETRY   = 2'b10;
    localparam logic [1:0] c_HRESP_SPLIT   = 2'b11;

    // Stream-writer FSM encoding
    localparam logic [1:0] c_ST_IDLE       = 2'b00;
    localparam logic [1:0] c_ST_RUN        = 2'b01;
    localparam logic [1:0] c_ST_FLUSH      = 2'b10;
    localparam logic [1:0] c_ST_ERR        = 2'b11;

    // RETRY and SPLIT are not supported by this master and count as errors
    function automatic logic hresp_is_error(input logic [1:0] hresp);
        logic v_err;
        v_err = 1'b0;
        case (hresp)
            c_HRESP_ERROR,
            c_HRESP_RETRY,
            c_HRESP_SPLIT: v_err = 1'b1;
            default:       v_err = 1'b0;
        endcase
        return v_err;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ahbl_stream_writer_if.sv
// ============================================================================
// Module      : ahbl_stream_writer_if
// Description : AHB-Lite master bus plus the valid/ready word stream feeding it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ahbl_stream_writer_if #(
    parameter int AHB_AWIDTH = 32,
    parameter int AHB_DWIDTH = 32
);
    // AHB-Lite bus
    logic [AHB_AWIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [AHB_DWIDTH-1:0] HWDATA;
    logic                  HREADY;
    logic [1:0]            HRESP;

    // Word stream
    logic                  S_VALID;
    logic [AHB_DWIDTH-1:0] S_DATA;
    logic                  S_READY;

    // Writer side: drives the bus, sinks the stream
    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        input  HREADY, HRESP,
        input  S_VALID, S_DATA,
        output S_READY
    );

    // Environment side: SRAM slave and stream source
    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        output HREADY, HRESP,
        output S_VALID, S_DATA,
        input  S_READY
    );

endinterface

`default_nettype wire

// File: rtl/ahbl_stream_writer.sv
// ============================================================================
// Module      : ahbl_stream_writer
// Description : Writes WORD_COUNT stream words to consecutive addresses from
//               BASE_ADDR as AHB-Lite INCR word writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahbl_stream_writer
    import ahbl_pkg::*;
#(
    parameter int AHB_AWIDTH = 32,
    parameter int AHB_DWIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic                  HCLK,
    input  wire logic                  HRESETN,
    input  wire logic                  START,
    input  wire logic [AHB_AWIDTH-1:0] BASE_ADDR,
    input  wire logic [CNT_WIDTH-1:0]  WORD_COUNT,
    output logic                       BUSY,
    output logic                       DONE,
    output logic                       ERROR,
    ahbl_stream_writer_if.master       bus
);

    logic [1:0]            r_state;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [CNT_WIDTH-1:0]  r_accepted;
    logic [CNT_WIDTH-1:0]  r_issued;
    logic [AHB_AWIDTH-1:0] r_next_addr;
    logic [AHB_DWIDTH-1:0] r_wdata_q;
    logic                  r_done;
    logic                  r_error;

    logic [AHB_AWIDTH-1:0] r_haddr;
    logic [1:0]            r_htrans;
    logic                  r_hwrite;
    logic [2:0]            r_hsize;
    logic [2:0]            r_hburst;
    logic [AHB_DWIDTH-1:0] r_hwdata;

    logic                  w_xfer;
    logic                  w_addr_done;
    logic                  w_err;
    logic                  w_s_ready;
    logic                  w_accept;
    logic                  w_start_ok;
    logic                  w_nonseq;

    // A real transfer occupies the address phase; it completes with HREADY
    assign w_xfer      = (r_htrans != c_HTRANS_IDLE) && (r_htrans != c_HTRANS_BUSY);
    assign w_addr_done = w_xfer && bus.HREADY;
    assign w_err       = hresp_is_error(bus.HRESP) && (r_state != c_ST_ERR);
    assign w_s_ready   = (r_state == c_ST_RUN) && (r_accepted < r_count) &&
                         ((r_htrans == c_HTRANS_IDLE) || bus.HREADY);
    assign w_accept    = bus.S_VALID && w_s_ready;
    assign w_start_ok  = START && (r_state == c_ST_IDLE);
    // Restart the burst after a gap, at job start, or on a 1 KB boundary
    assign w_nonseq    = (r_htrans == c_HTRANS_IDLE) || (r_accepted == '0) ||
                         (r_next_addr[9:0] == 10'd0);

    assign BUSY        = (r_state != c_ST_IDLE);
    assign DONE        = r_done;
    assign ERROR       = r_error;
    assign bus.S_READY = w_s_ready;
    assign bus.HADDR   = r_haddr;
    assign bus.HTRANS  = r_htrans;
    assign bus.HWRITE  = r_hwrite;
    assign bus.HSIZE   = r_hsize;
    assign bus.HBURST  = r_hburst;
    assign bus.HWDATA  = r_hwdata;

    // Job control FSM: word counters, DONE pulse and sticky ERROR
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_state    <= c_ST_IDLE;
            r_count    <= '0;
            r_accepted <= '0;
            r_issued   <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_err) begin
                r_state <= c_ST_ERR;
                r_error <= 1'b1;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (START) begin
                            r_error    <= 1'b0;
                            r_count    <= WORD_COUNT;
                            r_accepted <= '0;
                            r_issued   <= '0;
                            if (WORD_COUNT == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state <= c_ST_RUN;
                            end
                        end
                    end
                    c_ST_RUN: begin
                        if (w_accept) begin
                            r_accepted <= r_accepted + 1'b1;
                        end
                        if (w_addr_done) begin
                            r_issued <= r_issued + 1'b1;
                            if ((r_issued + 1'b1) == r_count) begin
                                r_state <= c_ST_FLUSH;
                            end
                        end
                    end
                    c_ST_FLUSH: begin
                        if (bus.HREADY) begin
                            r_state <= c_ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                    default: begin
                        // Second error cycle: the slave releases HREADY
                        if (bus.HREADY) begin
                            r_state <= c_ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // AHB address/data pipeline; everything holds while HREADY is low
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_haddr     <= '0;
            r_htrans    <= c_HTRANS_IDLE;
            r_hwrite    <= 1'b0;
            r_hsize     <= c_HSIZE_WORD;
            r_hburst    <= 3'b000;
            r_hwdata    <= '0;
            r_wdata_q   <= '0;
            r_next_addr <= '0;
        end else begin
            if (w_start_ok) begin
                r_next_addr <= BASE_ADDR;
            end
            if (w_err) begin
                // Cancel any pending address phase on the first error cycle
                r_htrans <= c_HTRANS_IDLE;
            end else if (w_accept) begin
                r_haddr     <= r_next_addr;
                r_htrans    <= w_nonseq ? c_HTRANS_NONSEQ : c_HTRANS_SEQ;
                r_hwrite    <= 1'b1;
                r_hsize     <= c_HSIZE_WORD;
                r_hburst    <= c_HBURST_INCR;
                r_wdata_q   <= bus.S_DATA;
                r_next_addr <= r_next_addr + AHB_AWIDTH'(4);
            end else if (bus.HREADY) begin
                r_htrans <= c_HTRANS_IDLE;
            end
            // Data follows its address phase by one cycle
            if (w_addr_done && !w_err) begin
                r_hwdata <= r_wdata_q;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ahbl_stream_writer.sv
// ============================================================================
// Module      : tb_ahbl_stream_writer
// Description : Directed self-checking bench for ahbl_stream_writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahbl_stream_writer;
    import ahbl_pkg::*;

    logic        HCLK;
    logic        HRESETN;
    logic        START;
    logic [31:0] BASE_ADDR;
    logic [15:0] WORD_COUNT;
    logic        BUSY;
    logic        DONE;
    logic        ERROR;

    int checks = 0;
    int errors = 0;

    ahbl_stream_writer_if #(.AHB_AWIDTH(32), .AHB_DWIDTH(32)) bus ();

    ahbl_stream_writer #(
        .AHB_AWIDTH (32),
        .AHB_DWIDTH (32),
        .CNT_WIDTH  (16)
    ) dut (
        .HCLK       (HCLK),
        .HRESETN    (HRESETN),
        .START      (START),
        .BASE_ADDR  (BASE_ADDR),
        .WORD_COUNT (WORD_COUNT),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ERROR      (ERROR),
        .bus        (bus.master)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then changed 1 ns after the edge
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Let combinational outputs settle before checking
    task automatic settle();
        #1;
    endtask

    task automatic chk_bus(input string tag, input logic [1:0] tr, input logic [31:0] ad);
        chk({tag, ".htrans"}, bus.HTRANS, tr);
        if (tr != c_HTRANS_IDLE) chk({tag, ".haddr"}, bus.HADDR, ad);
    endtask

    initial begin
        HRESETN     = 1'b0;
        START       = 1'b0;
        BASE_ADDR   = '0;
        WORD_COUNT  = '0;
        bus.HREADY  = 1'b1;
        bus.HRESP   = c_HRESP_OKAY;
        bus.S_VALID = 1'b0;
        bus.S_DATA  = '0;
        tick(); tick();

        // ---- reset state ----
        settle();
        chk("rst.htrans", bus.HTRANS, 2'b00);
        chk("rst.haddr",  bus.HADDR,  32'h0);
        chk("rst.hwdata", bus.HWDATA, 32'h0);
        chk("rst.hwrite", bus.HWRITE, 1'b0);
        chk("rst.hsize",  bus.HSIZE,  3'b010);
        chk("rst.hburst", bus.HBURST, 3'b000);
        chk("rst.busy",   BUSY,  1'b0);
        chk("rst.done",   DONE,  1'b0);
        chk("rst.error",  ERROR, 1'b0);
        chk("rst.sready", bus.S_READY, 1'b0);
        HRESETN = 1'b1;
        tick();

        // ---- back-to-back, with an ignored START mid-job ----
        START = 1'b1; BASE_ADDR = 32'h2000_0000; WORD_COUNT = 16'd4;
        bus.S_VALID = 1'b1; bus.S_DATA = 32'hA000_0000;
        tick();
        START = 1'b0; settle();
        chk("b2b.busy", BUSY, 1'b1);
        chk("b2b.sready0", bus.S_READY, 1'b1);
        chk_bus("b2b.c1", c_HTRANS_IDLE, 32'h0);
        tick();
        bus.S_DATA = 32'hA000_0001; settle();
        chk_bus("b2b.w0", c_HTRANS_NONSEQ, 32'h2000_0000);
        chk("b2b.hwrite", bus.HWRITE, 1'b1);
        chk("b2b.hsize",  bus.HSIZE,  3'b010);
        chk("b2b.hburst", bus.HBURST, 3'b001);
        tick();
        bus.S_DATA = 32'hA000_0002;
        START = 1'b1; BASE_ADDR = 32'h0000_FFF0; WORD_COUNT = 16'd1; settle();
        chk_bus("b2b.w1", c_HTRANS_SEQ, 32'h2000_0004);
        chk("b2b.d0", bus.HWDATA, 32'hA000_0000);
        tick();
        START = 1'b0; bus.S_DATA = 32'hA000_0003; settle();
        chk_bus("b2b.w2", c_HTRANS_SEQ, 32'h2000_0008);
        chk("b2b.d1", bus.HWDATA, 32'hA000_0001);
        tick();
        bus.S_VALID = 1'b0; settle();
        chk_bus("b2b.w3", c_HTRANS_SEQ, 32'h2000_000C);
        chk("b2b.d2", bus.HWDATA, 32'hA000_0002);
        chk("b2b.sready_full", bus.S_READY, 1'b0);
        tick(); settle();
        chk_bus("b2b.flush", c_HTRANS_IDLE, 32'h0);
        chk("b2b.d3", bus.HWDATA, 32'hA000_0003);
        chk("b2b.flush_done", DONE, 1'b0);
        chk("b2b.flush_busy", BUSY, 1'b1);
        tick(); settle();
        chk("b2b.done", DONE, 1'b1);
        chk("b2b.done_busy", BUSY, 1'b0);
        tick(); settle();
        chk("b2b.done_clr", DONE, 1'b0);
        chk_bus("b2b.after", c_HTRANS_IDLE, 32'h0);

        // ---- wait states on the 2nd address phase ----
        START = 1'b1; BASE_ADDR = 32'h0000_0100; WORD_COUNT = 16'd3;
        bus.S_VALID = 1'b1; bus.S_DATA = 32'hE000_0000;
        tick();
        START = 1'b0;
        tick();
        bus.S_DATA = 32'hE000_0001; settle();
        chk_bus("ws.w0", c_HTRANS_NONSEQ, 32'h0000_0100);
        tick();
        bus.HREADY = 1'b0; bus.S_DATA = 32'hE000_0002; settle();
        chk_bus("ws.w1a", c_HTRANS_SEQ, 32'h0000_0104);
        chk("ws.sready_a", bus.S_READY, 1'b0);
        tick(); settle();
        chk_bus("ws.w1b", c_HTRANS_SEQ, 32'h0000_0104);
        chk("ws.d0hold", bus.HWDATA, 32'hE000_0000);
        chk("ws.sready_b", bus.S_READY, 1'b0);
        tick();
        bus.HREADY = 1'b1; settle();
        chk_bus("ws.w1c", c_HTRANS_SEQ, 32'h0000_0104);
        chk("ws.sready_c", bus.S_READY, 1'b1);
        tick();
        bus.S_VALID = 1'b0; settle();
        chk_bus("ws.w2", c_HTRANS_SEQ, 32'h0000_0108);
        chk("ws.d1", bus.HWDATA, 32'hE000_0001);
        tick(); settle();
        chk("ws.d2", bus.HWDATA, 32'hE000_0002);
        tick(); settle();
        chk("ws.done", DONE, 1'b1);
        tick();

        // ---- stream gap after word 2 ----
        START = 1'b1; BASE_ADDR = 32'h0000_0200; WORD_COUNT = 16'd4;
        bus.S_VALID = 1'b1; bus.S_DATA = 32'hF000_0000;
        tick();
        START = 1'b0;
        tick();
        bus.S_DATA = 32'hF000_0001; settle();
        chk_bus("gap.w0", c_HTRANS_NONSEQ, 32'h0000_0200);
        tick();
        bus.S_VALID = 1'b0; settle();
        chk_bus("gap.w1", c_HTRANS_SEQ, 32'h0000_0204);
        tick(); settle();
        chk_bus("gap.i1", c_HTRANS_IDLE, 32'h0);
        chk("gap.d1", bus.HWDATA, 32'hF000_0001);
        tick(); settle();
        chk_bus("gap.i2", c_HTRANS_IDLE, 32'h0);
        tick();
        bus.S_VALID = 1'b1; bus.S_DATA = 32'hF000_0002; settle();
        chk_bus("gap.i3", c_HTRANS_IDLE, 32'h0);
        tick();
        bus.S_DATA = 32'hF000_0003; settle();
        chk_bus("gap.w2", c_HTRANS_NONSEQ, 32'h0000_0208);
        tick();
        bus.S_VALID = 1'b0; settle();
        chk_bus("gap.w3", c_HTRANS_SEQ, 32'h0000_020C);
        chk("gap.d2", bus.HWDATA, 32'hF000_0002);
        tick(); settle();
        chk("gap.d3", bus.HWDATA, 32'hF000_0003);
        tick(); settle();
        chk("gap.done", DONE, 1'b1);
        tick();

        // ---- 1 KB boundary crossing ----
        START = 1'b1; BASE_ADDR = 32'h0000_03F8; WORD_COUNT = 16'd4;
        bus.S_VALID = 1'b1; bus.S_DATA = 32'h1111_0000;
        tick();
        START = 1'b0;
        tick(); settle();
        chk_bus("kb.w0", c_HTRANS_NONSEQ, 32'h0000_03F8);
        tick(); settle();
        chk_bus("kb.w1", c_HTRANS_SEQ, 32'h0000_03FC);
        tick(); settle();
        chk_bus("kb.w2", c_HTRANS_NONSEQ, 32'h0000_0400);
        tick();
        bus.S_VALID = 1'b0; settle();
        chk_bus("kb.w3", c_HTRANS_SEQ, 32'h0000_0404);
        tick(); tick(); settle();
        chk("kb.done", DONE, 1'b1);
        tick();

        // ---- two-cycle ERROR response on word 2 ----
        START = 1'b1; BASE_ADDR = 32'h0000_0500; WORD_COUNT = 16'd4;
        bus.S_VALID = 1'b1; bus.S_DATA = 32'h6000_0000;
        tick();
        START = 1'b0;
        tick();
        bus.S_DATA = 32'h6000_0001; settle();
        chk_bus("err.w0", c_HTRANS_NONSEQ, 32'h0000_0500);
        tick();
        bus.S_DATA = 32'h6000_0002; settle();
        chk_bus("err.w1", c_HTRANS_SEQ, 32'h0000_0504);
        tick();
        bus.HREADY = 1'b0; bus.HRESP = c_HRESP_ERROR; settle();
        chk("err.d1", bus.HWDATA, 32'h6000_0001);
        chk_bus("err.w2", c_HTRANS_SEQ, 32'h0000_0508);
        chk("err.sready1", bus.S_READY, 1'b0);
        tick();
        bus.HREADY = 1'b1; settle();
        chk_bus("err.cancel", c_HTRANS_IDLE, 32'h0);
        chk("err.flag", ERROR, 1'b1);
        chk("err.busy2", BUSY, 1'b1);
        chk("err.done2", DONE, 1'b0);
        tick();
        bus.HRESP = c_HRESP_OKAY; settle();
        chk("err.done", DONE, 1'b1);
        chk("err.busy", BUSY, 1'b0);
        chk("err.sticky", ERROR, 1'b1);
        chk("err.sready", bus.S_READY, 1'b0);
        chk_bus("err.idle1", c_HTRANS_IDLE, 32'h0);
        tick(); settle();
        chk_bus("err.idle2", c_HTRANS_IDLE, 32'h0);
        chk("err.done_clr", DONE, 1'b0);
        chk("err.sticky2", ERROR, 1'b1);
        bus.S_VALID = 1'b0;

        // ---- zero count: DONE next cycle, clears ERROR, no transfer ----
        START = 1'b1; BASE_ADDR = 32'h0000_0700; WORD_COUNT = 16'd0;
        tick();
        START = 1'b0; settle();
        chk("zero.done", DONE, 1'b1);
        chk("zero.errclr", ERROR, 1'b0);
        chk("zero.busy", BUSY, 1'b0);
        chk_bus("zero.idle", c_HTRANS_IDLE, 32'h0);
        tick(); settle();
        chk("zero.done_clr", DONE, 1'b0);
        chk_bus("zero.idle2", c_HTRANS_IDLE, 32'h0);

        // ---- reset mid-job abandons it ----
        START = 1'b1; BASE_ADDR = 32'h0000_0800; WORD_COUNT = 16'd4;
        bus.S_VALID = 1'b1;
        tick();
        START = 1'b0;
        tick(); tick(); settle();
        chk_bus("mid.w1", c_HTRANS_SEQ, 32'h0000_0804);
        HRESETN = 1'b0; settle();
        chk("mid.htrans", bus.HTRANS, 2'b00);
        chk("mid.haddr",  bus.HADDR, 32'h0);
        chk("mid.busy",   BUSY, 1'b0);
        tick();
        HRESETN = 1'b1;
        tick(); tick(); settle();
        chk("mid.after_htrans", bus.HTRANS, 2'b00);
        chk("mid.after_sready", bus.S_READY, 1'b0);
        chk("mid.after_busy", BUSY, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
